// File: rtl/subbytes_fault_guard_if.sv
// Byte-serial valid/ready channel into and out of the SubBytes fault guard.
interface subbytes_fault_guard_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/subbytes_fault_guard.sv
// AES S-box lookup guarded by a (12,8) Hamming check with bounded retry and a sticky fault.
// One byte per 3 cycles at best; in_ready only in IDLE, output held until out_ready.
module subbytes_fault_guard #(
  parameter int MAX_RETRY = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  subbytes_fault_guard_if.slave bus,
  output logic                 fault,
  input  logic                 clear_fault,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [3:0]           last_syndrome,
  input  logic                 inj_en,
  input  logic [11:0]          inj_mask
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0 sits in the most significant bits, hence the inverted index.
  function automatic logic [7:0] sub_bytes(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  // Data bits occupy Hamming positions 3,5,6,7,9,10,11,12; parity at 1,2,4,8.
  function automatic logic [3:0] ham_parity(input logic [7:0] d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return p;
  endfunction

  function automatic logic [3:0] ham_predict(input logic [7:0] x);
    return ham_parity(sub_bytes(x));
  endfunction

  function automatic logic [3:0] ham_check(input logic [11:0] c);
    return ham_parity(c[11:4]) ^ c[3:0];
  endfunction

  typedef enum logic [1:0] {IDLE, CHECK, HOLD, FAULT} state_t;

  state_t      state;
  logic [3:0]  retry_cnt;
  logic [7:0]  data_r;
  logic [11:0] code;
  logic [3:0]  syn;

  always_comb begin
    code = {sub_bytes(data_r), ham_predict(data_r)} ^ (inj_en ? inj_mask : 12'h000);
    syn  = ham_check(code);
  end

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      retry_cnt     <= '0;
      data_r        <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      fault         <= 1'b0;
      err_count     <= '0;
      last_syndrome <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_r    <= bus.in_data;
            retry_cnt <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (syn == 4'h0) begin
            bus.out_data  <= code[11:4];
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end else begin
            last_syndrome <= syn;
            if (err_count != {ERR_CNT_W{1'b1}})
              err_count <= err_count + ERR_CNT_W'(1);
            if (retry_cnt < 4'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 4'd1;
            end else begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_fault_guard.sv
// Directed bench for subbytes_fault_guard: reference S-box built from GF(2^8) inversion.
module tb_subbytes_fault_guard;
  logic        clk = 1'b0;
  logic        rst;
  logic        fault, fault2;
  logic        clear_fault, clear_fault2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  logic [3:0]  last_syndrome, last_syndrome2;
  logic        inj_en, inj_en2;
  logic [11:0] inj_mask, inj_mask2;

  int n_checks = 0;
  int n_errors = 0;

  subbytes_fault_guard_if bus ();
  subbytes_fault_guard_if bus2 ();

  subbytes_fault_guard #(.MAX_RETRY(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fault(fault), .clear_fault(clear_fault),
    .err_count(err_count), .last_syndrome(last_syndrome), .inj_en(inj_en), .inj_mask(inj_mask)
  );

  subbytes_fault_guard #(.MAX_RETRY(0), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .fault(fault2), .clear_fault(clear_fault2),
    .err_count(err_count2), .last_syndrome(last_syndrome2), .inj_en(inj_en2), .inj_mask(inj_mask2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Handshake one byte; returns #1 after the accepting edge (DUT now in CHECK).
  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    while (!bus.in_ready && t < 20) begin
      step();
      t++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'h00, 8'h63};
    vecs[1] = '{8'h01, 8'h7c};
    vecs[2] = '{8'h10, 8'hca};
    vecs[3] = '{8'h53, 8'hed};
    vecs[4] = '{8'h7f, 8'hd2};
    vecs[5] = '{8'h80, 8'hcd};
    vecs[6] = '{8'hc3, 8'h2e};
    vecs[7] = '{8'hff, 8'h16};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.out_ready = 1'b1;
    clear_fault = 1'b0; clear_fault2 = 1'b0;
    inj_en = 1'b0; inj_mask = 12'h000;
    inj_en2 = 1'b0; inj_mask2 = 12'h000;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_last_syndrome", 32'(last_syndrome), 32'd0);

    // Hand-computed S-box vectors, with latency and clean status.
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].din);
      chk($sformatf("vec%0d_check_cycle_valid", i), 32'(bus.out_valid), 32'd0);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'd0);
    end

    // Full sweep against the computed reference.
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      wait_out(lat);
      chk($sformatf("sweep_%02h", i), 32'(bus.out_data), 32'(ref_sbox(8'(i))));
      chk($sformatf("sweep_fault_%02h", i), 32'(fault), 32'd0);
    end

    // Single transient error: one retry then clean output.
    send_byte(8'h53);
    inj_en = 1'b1; inj_mask = 12'h010;
    step();
    inj_en = 1'b0; inj_mask = 12'h000;
    chk("retry_out_valid_low", 32'(bus.out_valid), 32'd0);
    chk("retry_err_count_1", 32'(err_count), 32'd1);
    step();
    chk("retry_out_valid", 32'(bus.out_valid), 32'd1);
    chk("retry_out_data", 32'(bus.out_data), 32'hed);
    chk("retry_syndrome_nonzero", 32'(last_syndrome != 4'h0), 32'd1);
    chk("retry_fault", 32'(fault), 32'd0);

    // Persistent error: exhaust retry budget and enter FAULT.
    send_byte(8'h11);
    inj_en = 1'b1; inj_mask = 12'h003;
    step();
    chk("perm_c1_fault", 32'(fault), 32'd0);
    step();
    chk("perm_c2_fault", 32'(fault), 32'd0);
    chk("perm_c2_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("perm_fault", 32'(fault), 32'd1);
    chk("perm_err_count", 32'(err_count), 32'd4);
    chk("perm_in_ready", 32'(bus.in_ready), 32'd0);
    chk("perm_out_valid", 32'(bus.out_valid), 32'd0);
    chk("perm_syndrome_nonzero", 32'(last_syndrome != 4'h0), 32'd1);
    inj_en = 1'b0; inj_mask = 12'h000;
    bus.in_valid = 1'b1; bus.in_data = 8'h22;
    step();
    step();
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_no_accept", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("clear_fault", 32'(fault), 32'd0);
    chk("clear_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clear_keeps_err_count", 32'(err_count), 32'd4);
    chk("clear_no_output", 32'(bus.out_valid), 32'd0);

    // Downstream stall in HOLD for 5 cycles.
    bus.out_ready = 1'b0;
    send_byte(8'ha5);
    step();
    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_out_data", 32'(bus.out_data), 32'h06);
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_out_data", i), 32'(bus.out_data), 32'h06);
      chk($sformatf("stall%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("release_stay_idle", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of CHECK discards the byte.
    send_byte(8'h53);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'h00);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_last_syndrome", 32'(last_syndrome), 32'd0);
    chk("midrst_fault", 32'(fault), 32'd0);
    step();
    chk("midrst_discarded", 32'(bus.out_valid), 32'd0);

    // Narrow counter, no retries, permanent error over several bytes.
    inj_en2 = 1'b1; inj_mask2 = 12'h800;
    for (int k = 1; k <= 5; k++) begin
      bus2.in_valid = 1'b1; bus2.in_data = 8'(k);
      step();
      bus2.in_valid = 1'b0;
      step();
      chk($sformatf("sat%0d_fault", k), 32'(fault2), 32'd1);
      chk($sformatf("sat%0d_err_count", k), 32'(err_count2), 32'(k > 3 ? 3 : k));
      chk($sformatf("sat%0d_out_valid", k), 32'(bus2.out_valid), 32'd0);
      clear_fault2 = 1'b1;
      step();
      clear_fault2 = 1'b0;
      chk($sformatf("sat%0d_cleared", k), 32'(fault2), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
